// File: rtl/stream_upsizer_pkg.sv
// Purpose: shared types and helpers for the stream upsizer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stream_upsizer_pkg;

   // Accumulator states: FILL gathers beats, HOLD parks a completed word
   // until the output register can take it.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } acc_state_e;

   // Lane counter width; at least one bit, so Ratio=1 still has a counter.
   function automatic int unsigned lane_width(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/stream_upsizer_timer.sv
// Purpose: idle-cycle counter that flushes a partially filled word.
// Latency: expire_o is combinational in the cycle the count reaches TimeoutCycles.
// Backpressure: none; counts only while en_i is high and no beat is accepted.
// Ports: clk_i/rst_ni/clr_i clock, async reset, sync clear; en_i partial word
//        pending; beat_i beat accepted this cycle; expire_o flush request.
module stream_upsizer_timer #(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   input  logic beat_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // The count holds the number of idle cycles already completed, so the
   // TimeoutCycles-th idle cycle is the one where cnt_q == TimeoutCycles-1.
   // An accepted beat in that cycle suppresses the flush.
   assign expire_o = en_i & ~beat_i & (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!en_i || beat_i || expire_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stream_upsizer.sv
// Purpose: packs Ratio narrow beats into one wide word (lane 0 first).
// Latency: word presented on valid_o one cycle after its completing beat.
// Backpressure: output register stalls on ready_i=0; a second completed word
//               parks in the accumulator (HOLD) and ready_o drops until it moves.
// Ports: clk_i, rst_ni (async, active-low), clr_i (sync clear);
//        input stream data_i/last_i/valid_i/ready_o;
//        output stream data_o/strb_o/last_o/valid_o/ready_i.
// Option: STREAM_UPSIZER_TIMEOUT_EN enables idle flush of partial words.
module stream_upsizer
   import stream_upsizer_pkg::*;
#(
   parameter int unsigned DataWidth     = 8,
   parameter int unsigned Ratio         = 4,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clr_i,
   input  logic [DataWidth-1:0]         data_i,
   input  logic                         last_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   output logic [Ratio*DataWidth-1:0]   data_o,
   output logic [Ratio-1:0]             strb_o,
   output logic                         last_o,
   output logic                         valid_o,
   input  logic                         ready_i
);

   localparam int unsigned LaneW = lane_width(Ratio);
   localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);
   localparam int unsigned WordW = Ratio * DataWidth;

   acc_state_e              state_q, state_d;
   logic [LaneW-1:0]        lane_q, lane_d;
   logic [WordW-1:0]        acc_data_q, acc_data_d;
   logic [Ratio-1:0]        acc_strb_q, acc_strb_d;
   logic                    acc_last_q, acc_last_d;
   logic [WordW-1:0]        out_data_q, out_data_d;
   logic [Ratio-1:0]        out_strb_q, out_strb_d;
   logic                    out_last_q, out_last_d;
   logic                    out_vld_q, out_vld_d;

   logic [WordW-1:0]        word_data;
   logic [Ratio-1:0]        word_strb;
   logic                    word_last;
   logic                    word_done;
   logic                    beat_acc;
   logic                    out_free;
   logic                    timeout_flush;

   // ready_o is a pure function of state, never of valid_i.
   assign ready_o  = (state_q == ST_FILL);
   assign beat_acc = valid_i & ready_o;
   // The output register can load when empty or draining this cycle.
   assign out_free = ~out_vld_q | ready_i;

`ifdef STREAM_UPSIZER_TIMEOUT_EN
   stream_upsizer_timer #(
      .TimeoutCycles (TimeoutCycles)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clr_i),
      .en_i     ((state_q == ST_FILL) && (lane_q != '0)),
      .beat_i   (beat_acc),
      .expire_o (timeout_flush)
   );
`else
   assign timeout_flush = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      acc_data_d = acc_data_q;
      acc_strb_d = acc_strb_q;
      acc_last_d = acc_last_q;
      out_vld_d  = out_vld_q & ~ready_i;
      out_data_d = out_data_q;
      out_strb_d = out_strb_q;
      out_last_d = out_last_q;

      // Candidate word: accumulator plus this cycle's beat, if any.
      word_data = acc_data_q;
      word_strb = acc_strb_q;
      word_last = acc_last_q;
      word_done = 1'b0;

      if (state_q == ST_FILL) begin
         if (beat_acc) begin
            word_data[lane_q*DataWidth +: DataWidth] = data_i;
            word_strb[lane_q] = 1'b1;
            word_last = last_i;
            word_done = last_i | (lane_q == LastLane);
         end else if (timeout_flush) begin
            word_done = 1'b1;
         end

         if (word_done) begin
            lane_d = '0;
            if (out_free) begin
               out_vld_d  = 1'b1;
               out_data_d = word_data;
               out_strb_d = word_strb;
               out_last_d = word_last;
               acc_data_d = '0;
               acc_strb_d = '0;
               acc_last_d = 1'b0;
            end else begin
               state_d    = ST_HOLD;
               acc_data_d = word_data;
               acc_strb_d = word_strb;
               acc_last_d = word_last;
            end
         end else if (beat_acc) begin
            lane_d     = lane_q + 1'b1;
            acc_data_d = word_data;
            acc_strb_d = word_strb;
         end
      end else begin
         if (out_free) begin
            state_d    = ST_FILL;
            lane_d     = '0;
            out_vld_d  = 1'b1;
            out_data_d = acc_data_q;
            out_strb_d = acc_strb_q;
            out_last_d = acc_last_q;
            acc_data_d = '0;
            acc_strb_d = '0;
            acc_last_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_FILL;
         lane_q     <= '0;
         acc_data_q <= '0;
         acc_strb_q <= '0;
         acc_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_strb_q <= '0;
         out_last_q <= 1'b0;
      end else if (clr_i) begin
         state_q    <= ST_FILL;
         lane_q     <= '0;
         acc_data_q <= '0;
         acc_strb_q <= '0;
         acc_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_strb_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         acc_data_q <= acc_data_d;
         acc_strb_q <= acc_strb_d;
         acc_last_q <= acc_last_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_strb_q <= out_strb_d;
         out_last_q <= out_last_d;
      end
   end

   assign valid_o = out_vld_q;
   assign data_o  = out_data_q;
   assign strb_o  = out_strb_q;
   assign last_o  = out_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Purpose: directed scoreboard bench for stream_upsizer (Ratio=4, 8-bit beats).
// Latency: checks one-cycle word latency and idle-flush timing when enabled.
// Backpressure: exercises ready_i stalls, HOLD, clear and reset mid-word.
module tb_stream_upsizer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clr_i = 1'b0;
   logic [7:0]  data_i = '0;
   logic        last_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] data_o;
   logic [3:0]  strb_o;
   logic        last_o;
   logic        valid_o;
   logic        ready_i = 1'b1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   logic        prev_stall = 1'b0;
   exp_t        prev_word;

   stream_upsizer #(
      .DataWidth     (8),
      .Ratio         (4),
      .TimeoutCycles (16)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .data_i  (data_i),
      .last_i  (last_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .strb_o  (strb_o),
      .last_o  (last_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: pops and compares on every output handshake, and checks that a
   // stalled word does not change until it is taken.
   always @(negedge clk_i) begin
      if (rst_ni && !clr_i) begin
         if (prev_stall) begin
            checks++;
            if (!valid_o || data_o !== prev_word.data || strb_o !== prev_word.strb
                || last_o !== prev_word.last) begin
               errors++;
               $display("FAIL stall_stable got vld=%b data=%h strb=%b last=%b want vld=1 data=%h strb=%b last=%b",
                        valid_o, data_o, strb_o, last_o, prev_word.data, prev_word.strb, prev_word.last);
            end
         end
         if (valid_o && ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word got data=%h strb=%b last=%b want none", data_o, strb_o, last_o);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (data_o !== e.data || strb_o !== e.strb || last_o !== e.last) begin
                  errors++;
                  $display("FAIL word got data=%h strb=%b last=%b want data=%h strb=%b last=%b",
                           data_o, strb_o, last_o, e.data, e.strb, e.last);
               end
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_word  = '{data: data_o, strb: strb_o, last: last_o};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
      exp_q.push_back('{data: d, strb: s, last: l});
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      data_i  = d;
      last_i  = l;
      valid_i = 1'b1;
      @(negedge clk_i);
      while (!ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL send_wait got ready_o=0 want ready_o=1 within 50 cycles");
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      int c0;
      int n;

      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_strb", {28'd0, strb_o}, 32'd0);
      chk("rst_last", {31'd0, last_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk_i);
      #1;

      // Full word, one-cycle latency
      push(32'h44332211, 4'b1111, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      chk("latency_valid", {31'd0, valid_o}, 32'd1);

      // Short word closed by last
      push(32'h0000BBAA, 4'b0011, 1'b1);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      chk("short_valid", {31'd0, valid_o}, 32'd1);

      // Throughput: two words in eight cycles
      push(32'h04030201, 4'b1111, 1'b0);
      push(32'h08070605, 4'b1111, 1'b0);
      c0 = cyc;
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      chk("throughput_cycles", 32'(cyc - c0), 32'd8);

      // Single beat with last
      push(32'h000000C3, 4'b0001, 1'b1);
      send(8'hC3, 1'b1);
      tick(2);

      // Backpressure: second word parks in HOLD
      ready_i = 1'b0;
      push(32'h13121110, 4'b1111, 1'b0);
      push(32'h17161514, 4'b1111, 1'b0);
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
      chk("hold_ready", {31'd0, ready_o}, 32'd0);
      chk("hold_out_data", data_o, 32'h13121110);
      tick(3);
      chk("hold_ready_still", {31'd0, ready_o}, 32'd0);
      ready_i = 1'b1;
      tick(1);
      ready_i = 1'b0;
      chk("hold_release_ready", {31'd0, ready_o}, 32'd1);
      chk("hold_release_data", data_o, 32'h17161514);
      chk("hold_release_valid", {31'd0, valid_o}, 32'd1);
      tick(2);
      ready_i = 1'b1;
      tick(2);

      // Clear with a partial word
      send(8'hE1, 1'b0);
      send(8'hE2, 1'b0);
      clr_i = 1'b1;
      tick(1);
      clr_i = 1'b0;
      chk("clr_partial_valid", {31'd0, valid_o}, 32'd0);
      chk("clr_partial_ready", {31'd0, ready_o}, 32'd1);
      push(32'hD3D2D1D0, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), 1'b0);
      tick(2);

      // Clear with a held word and a stalled output word
      ready_i = 1'b0;
      for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b0);
      chk("clr_hold_pre_ready", {31'd0, ready_o}, 32'd0);
      clr_i = 1'b1;
      tick(1);
      clr_i = 1'b0;
      chk("clr_hold_valid", {31'd0, valid_o}, 32'd0);
      chk("clr_hold_ready", {31'd0, ready_o}, 32'd1);
      chk("clr_hold_data", data_o, 32'd0);
      ready_i = 1'b1;
      push(32'hA3A2A1A0, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
      tick(2);

      // Reset mid-word: no partial word afterwards
      send(8'hF1, 1'b0);
      send(8'hF2, 1'b0);
      rst_ni = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      tick(1);
      chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
      push(32'hB3B2B1B0, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b0);
      tick(2);

`ifdef STREAM_UPSIZER_TIMEOUT_EN
      // Idle flush after 16 idle cycles
      push(32'h0000005A, 4'b0001, 1'b0);
      send(8'h5A, 1'b0);
      n = 0;
      while (!valid_o && n < 40) begin
         tick(1);
         n++;
      end
      chk("timeout_idle_cycles", 32'(n), 32'd16);
      tick(2);

      // Beat in the 16th idle cycle wins over the flush
      push(32'h44332211, 4'b1111, 1'b0);
      send(8'h11, 1'b0);
      tick(15);
      send(8'h22, 1'b0);
      chk("timeout_beat_wins", {31'd0, valid_o}, 32'd0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      tick(2);
`else
      // Without the idle flush, a partial word waits for last
      send(8'h5A, 1'b0);
      tick(24);
      chk("no_timeout_valid", {31'd0, valid_o}, 32'd0);
      push(32'h00005B5A, 4'b0011, 1'b1);
      send(8'h5B, 1'b1);
      tick(2);
`endif

      tick(4);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
